// File: rtl/channelif_n_if.sv
// Ethernet-side framed byte stream bundle for the channel interface.
// master = ethernet platform, slave = channelif_n.
interface channelif_n_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              in_sof;
    logic              in_eof;
    logic              in_src_rdy;
    logic              in_dst_rdy;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] inport_addr;
    logic              out_sof;
    logic              out_eof;
    logic              out_src_rdy;
    logic              out_dst_rdy;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] outport_addr;

    modport master (
        output in_sof, in_eof, in_src_rdy, in_data, inport_addr,
        output out_dst_rdy, outport_addr,
        input  in_dst_rdy, out_sof, out_eof, out_src_rdy, out_data
    );

    modport slave (
        input  in_sof, in_eof, in_src_rdy, in_data, inport_addr,
        input  out_dst_rdy, outport_addr,
        output in_dst_rdy, out_sof, out_eof, out_src_rdy, out_data
    );
endinterface

// File: rtl/channelif_n.sv
// FCP channel interface: routes framed byte streams between the ethernet
// platform and NUM_CH channels, locking the port address from SOF to EOF.
//
// state   | meaning
// I_IDLE  | no inbound frame open; live inport_addr selects the channel
// I_FRAME | inbound frame open to a mapped channel (latched address)
// I_DROP  | inbound frame to an unmapped address is being sunk
// O_IDLE  | no outbound frame open; live outport_addr selects the channel
// O_FRAME | outbound frame open from the latched channel
module channelif_n #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    channelif_n_if.slave             eth,
    input  logic [NUM_CH-1:0]        ch_in_sof,
    input  logic [NUM_CH-1:0]        ch_in_eof,
    input  logic [NUM_CH-1:0]        ch_in_src_rdy,
    output logic [NUM_CH-1:0]        ch_in_dst_rdy,
    input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
    output logic [NUM_CH-1:0]        ch_out_sof,
    output logic [NUM_CH-1:0]        ch_out_eof,
    output logic [NUM_CH-1:0]        ch_out_src_rdy,
    input  logic [NUM_CH-1:0]        ch_out_dst_rdy,
    output logic [NUM_CH*DATA_W-1:0] ch_out_data,
    output logic [NUM_CH-1:0]        ch_wen,
    output logic [NUM_CH-1:0]        ch_ren,
    output logic [2**ADDR_W-1:0]     wenables,
    output logic [2**ADDR_W-1:0]     renables,
    output logic [15:0]              in_frames,
    output logic [7:0]               drop_cnt
);
    localparam int NA = 2**ADDR_W;

    typedef enum logic [1:0] {I_IDLE, I_FRAME, I_DROP} in_state_t;
    typedef enum logic       {O_IDLE, O_FRAME} out_state_t;

    in_state_t   i_state, i_next;
    out_state_t  o_state, o_next;
    logic [ADDR_W-1:0] in_addr_q, out_addr_q, ea_in, ea_out;
    logic        in_map, out_map;
    logic        in_rdy, wen_act, latch_in, frame_done, drop_inc, in_go;
    logic        latch_out, out_xfer;

    // Channel-side vectors widened to the address space so address k indexes bit k.
    logic [NA-1:0]     rdy_ext, sof_ext, eof_ext, src_ext;
    logic [DATA_W-1:0] data_ext [NA];

    assign rdy_ext = NA'({ch_out_dst_rdy, 1'b0});
    assign sof_ext = NA'({ch_in_sof, 1'b0});
    assign eof_ext = NA'({ch_in_eof, 1'b0});
    assign src_ext = NA'({ch_in_src_rdy, 1'b0});

    always_comb begin
        for (int k = 0; k < NA; k++) data_ext[k] = '0;
        for (int k = 1; k <= NUM_CH; k++) data_ext[k] = ch_in_data[k*DATA_W-1 -: DATA_W];
    end

    assign ea_in   = (i_state == I_IDLE) ? eth.inport_addr  : in_addr_q;
    assign ea_out  = (o_state == O_IDLE) ? eth.outport_addr : out_addr_q;
    assign in_map  = (ea_in  != '0) && (32'(ea_in)  <= 32'(NUM_CH));
    assign out_map = (ea_out != '0) && (32'(ea_out) <= 32'(NUM_CH));
    assign in_go   = eth.in_src_rdy && !rst;

    always_comb begin
        i_next     = i_state;
        in_rdy     = 1'b0;
        wen_act    = 1'b0;
        latch_in   = 1'b0;
        frame_done = 1'b0;
        drop_inc   = 1'b0;
        unique case (i_state)
            I_IDLE: begin
                if (eth.in_sof && in_map) begin
                    wen_act = 1'b1;
                    in_rdy  = rdy_ext[ea_in];
                    if (in_go && in_rdy) begin
                        if (eth.in_eof) frame_done = 1'b1;
                        else begin
                            i_next   = I_FRAME;
                            latch_in = 1'b1;
                        end
                    end
                end else if (eth.in_sof) begin
                    in_rdy = 1'b1;
                    if (in_go) begin
                        drop_inc = 1'b1;
                        if (!eth.in_eof) begin
                            i_next   = I_DROP;
                            latch_in = 1'b1;
                        end
                    end
                end else begin
                    // stray beat outside any frame: accept and discard
                    in_rdy = 1'b1;
                    if (in_go) drop_inc = 1'b1;
                end
            end
            I_FRAME: begin
                wen_act = 1'b1;
                in_rdy  = rdy_ext[ea_in];
                if (in_go && in_rdy && eth.in_eof) begin
                    i_next     = I_IDLE;
                    frame_done = 1'b1;
                end
            end
            I_DROP: begin
                in_rdy = 1'b1;
                if (in_go && eth.in_eof) i_next = I_IDLE;
            end
            default: i_next = I_IDLE;
        endcase
    end

    assign out_xfer = eth.out_src_rdy && eth.out_dst_rdy;

    always_comb begin
        o_next    = o_state;
        latch_out = 1'b0;
        unique case (o_state)
            O_IDLE: if (out_xfer && eth.out_sof && !eth.out_eof) begin
                o_next    = O_FRAME;
                latch_out = 1'b1;
            end
            O_FRAME: if (out_xfer && eth.out_eof) o_next = O_IDLE;
            default: o_next = O_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state    <= I_IDLE;
            o_state    <= O_IDLE;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            in_frames  <= '0;
            drop_cnt   <= '0;
        end else begin
            i_state <= i_next;
            o_state <= o_next;
            if (latch_in)  in_addr_q  <= ea_in;
            if (latch_out) out_addr_q <= ea_out;
            if (frame_done) in_frames <= in_frames + 16'd1;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign wenables        = NA'(1) << ea_in;
    assign renables        = NA'(1) << ea_out;
    assign ch_wen          = wenables[NUM_CH:1] & {NUM_CH{wen_act}};
    assign ch_ren          = renables[NUM_CH:1];
    assign eth.in_dst_rdy  = in_rdy && !rst;
    assign ch_out_src_rdy  = ch_wen & {NUM_CH{in_go}};
    assign ch_out_sof      = {NUM_CH{eth.in_sof}};
    assign ch_out_eof      = {NUM_CH{eth.in_eof}};
    assign ch_out_data     = {NUM_CH{eth.in_data}};

    assign eth.out_src_rdy = out_map && src_ext[ea_out] && !rst;
    assign eth.out_sof     = out_map && sof_ext[ea_out];
    assign eth.out_eof     = out_map && eof_ext[ea_out];
    assign eth.out_data    = out_map ? data_ext[ea_out] : '0;
    assign ch_in_dst_rdy   = ch_ren & {NUM_CH{out_map && eth.out_dst_rdy && !rst}};
endmodule

// File: tb/tb_channelif_n.sv
// Directed bench for channelif_n with three channels: inbound routing,
// address locking, drops, outbound backpressure, reset and back-to-back frames.
module tb_channelif_n;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH-1:0]        ch_in_sof, ch_in_eof, ch_in_src_rdy, ch_in_dst_rdy;
    logic [NUM_CH*DATA_W-1:0] ch_in_data;
    logic [NUM_CH-1:0]        ch_out_sof, ch_out_eof, ch_out_src_rdy, ch_out_dst_rdy;
    logic [NUM_CH*DATA_W-1:0] ch_out_data;
    logic [NUM_CH-1:0]        ch_wen, ch_ren;
    logic [2**ADDR_W-1:0]     wenables, renables;
    logic [15:0]              in_frames;
    logic [7:0]               drop_cnt;
    int pass_cnt = 0;
    int total_cnt = 0;

    channelif_n_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) eth ();

    channelif_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .eth(eth),
        .ch_in_sof(ch_in_sof), .ch_in_eof(ch_in_eof), .ch_in_src_rdy(ch_in_src_rdy),
        .ch_in_dst_rdy(ch_in_dst_rdy), .ch_in_data(ch_in_data),
        .ch_out_sof(ch_out_sof), .ch_out_eof(ch_out_eof), .ch_out_src_rdy(ch_out_src_rdy),
        .ch_out_dst_rdy(ch_out_dst_rdy), .ch_out_data(ch_out_data),
        .ch_wen(ch_wen), .ch_ren(ch_ren), .wenables(wenables), .renables(renables),
        .in_frames(in_frames), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic in_beat(input logic sof, input logic eof, input logic [3:0] addr,
                           input logic [7:0] data);
        @(negedge clk);
        eth.in_src_rdy  = 1'b1;
        eth.in_sof      = sof;
        eth.in_eof      = eof;
        eth.inport_addr = addr;
        eth.in_data     = data;
        #1;
    endtask

    task automatic in_idle();
        @(negedge clk);
        eth.in_src_rdy = 1'b0;
        eth.in_sof     = 1'b0;
        eth.in_eof     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        eth.in_src_rdy = 1'b1; eth.in_sof = 1'b1; eth.in_eof = 1'b0;
        eth.inport_addr = 4'd1; eth.in_data = 8'h00;
        eth.out_dst_rdy = 1'b1; eth.outport_addr = 4'd1;
        ch_in_sof = '0; ch_in_eof = '0; ch_in_src_rdy = 3'b001;
        ch_in_data = 24'hA5_5A_11; ch_out_dst_rdy = 3'b111;
        @(negedge clk); @(negedge clk); #1;
        total_cnt++; if (eth.in_dst_rdy !== 1'b0) $display("FAIL rst_in_dst_rdy got %b want 0", eth.in_dst_rdy); else pass_cnt++;
        total_cnt++; if (eth.out_src_rdy !== 1'b0) $display("FAIL rst_out_src_rdy got %b want 0", eth.out_src_rdy); else pass_cnt++;
        total_cnt++; if (ch_out_src_rdy !== 3'b000) $display("FAIL rst_ch_out_src_rdy got %b want 000", ch_out_src_rdy); else pass_cnt++;
        total_cnt++; if (ch_in_dst_rdy !== 3'b000) $display("FAIL rst_ch_in_dst_rdy got %b want 000", ch_in_dst_rdy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; eth.in_src_rdy = 1'b0; eth.in_sof = 1'b0;
        #1;
        total_cnt++; if (in_frames !== 16'd0) $display("FAIL rst_in_frames got %0d want 0", in_frames); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); else pass_cnt++;
        total_cnt++; if (eth.out_src_rdy !== 1'b1) $display("FAIL post_rst_out_src_rdy got %b want 1", eth.out_src_rdy); else pass_cnt++;
        ch_in_src_rdy = '0;
    endtask

    task automatic test_basic();
        logic [7:0] d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            in_beat(i == 0, i == 3, 4'd2, d[i]);
            total_cnt++; if (ch_out_src_rdy !== 3'b010) $display("FAIL basic_src_rdy beat%0d got %b want 010", i, ch_out_src_rdy); else pass_cnt++;
            total_cnt++; if (ch_out_data !== {3{d[i]}}) $display("FAIL basic_data beat%0d got %h want %h", i, ch_out_data, {3{d[i]}}); else pass_cnt++;
            total_cnt++; if (wenables !== 16'h0004) $display("FAIL basic_wenables beat%0d got %h want 0004", i, wenables); else pass_cnt++;
            total_cnt++; if (eth.in_dst_rdy !== 1'b1) $display("FAIL basic_in_dst_rdy beat%0d got %b want 1", i, eth.in_dst_rdy); else pass_cnt++;
        end
        in_idle();
        total_cnt++; if (in_frames !== 16'd1) $display("FAIL basic_in_frames got %0d want 1", in_frames); else pass_cnt++;
    endtask

    task automatic test_addr_change();
        for (int i = 0; i < 4; i++) begin
            in_beat(i == 0, i == 3, (i < 2) ? 4'd2 : 4'd3, 8'h10 + 8'(i));
            total_cnt++; if (ch_out_src_rdy !== 3'b010) $display("FAIL lock_src_rdy beat%0d got %b want 010", i, ch_out_src_rdy); else pass_cnt++;
            total_cnt++; if (wenables !== 16'h0004) $display("FAIL lock_wenables beat%0d got %h want 0004", i, wenables); else pass_cnt++;
        end
        in_beat(1'b1, 1'b1, 4'd3, 8'h77);
        total_cnt++; if (ch_out_src_rdy !== 3'b100) $display("FAIL next_frame_src_rdy got %b want 100", ch_out_src_rdy); else pass_cnt++;
        total_cnt++; if (wenables !== 16'h0008) $display("FAIL next_frame_wenables got %h want 0008", wenables); else pass_cnt++;
        in_idle();
        total_cnt++; if (in_frames !== 16'd3) $display("FAIL lock_in_frames got %0d want 3", in_frames); else pass_cnt++;
    endtask

    task automatic test_drop();
        ch_out_dst_rdy = 3'b000;
        // beat 1 carries a mid-frame sof to a mapped address; it must stay sunk
        for (int i = 0; i < 3; i++) begin
            in_beat(i < 2, i == 2, (i == 0) ? 4'd0 : 4'd1, 8'h20 + 8'(i));
            total_cnt++; if (eth.in_dst_rdy !== 1'b1) $display("FAIL drop_in_dst_rdy beat%0d got %b want 1", i, eth.in_dst_rdy); else pass_cnt++;
            total_cnt++; if (ch_out_src_rdy !== 3'b000) $display("FAIL drop_src_rdy beat%0d got %b want 000", i, ch_out_src_rdy); else pass_cnt++;
            total_cnt++; if (wenables !== 16'h0001) $display("FAIL drop_wenables beat%0d got %h want 0001", i, wenables); else pass_cnt++;
        end
        in_beat(1'b1, 1'b1, 4'd7, 8'h99);
        total_cnt++; if (eth.in_dst_rdy !== 1'b1) $display("FAIL drop7_in_dst_rdy got %b want 1", eth.in_dst_rdy); else pass_cnt++;
        total_cnt++; if (wenables !== 16'h0080) $display("FAIL drop7_wenables got %h want 0080", wenables); else pass_cnt++;
        total_cnt++; if (ch_out_src_rdy !== 3'b000) $display("FAIL drop7_src_rdy got %b want 000", ch_out_src_rdy); else pass_cnt++;
        in_idle();
        total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL drop_cnt got %0d want 2", drop_cnt); else pass_cnt++;
        total_cnt++; if (in_frames !== 16'd3) $display("FAIL drop_in_frames got %0d want 3", in_frames); else pass_cnt++;
        ch_out_dst_rdy = 3'b111;
    endtask

    task automatic test_outbound();
        @(negedge clk);
        eth.outport_addr = 4'd1; eth.out_dst_rdy = 1'b1;
        ch_in_src_rdy = 3'b001; ch_in_sof = 3'b001; ch_in_eof = 3'b000;
        ch_in_data = 24'hA5_5A_11;
        #1;
        total_cnt++; if (eth.out_src_rdy !== 1'b1 || eth.out_sof !== 1'b1) $display("FAIL out_beat1_ctl got src%b sof%b want 1 1", eth.out_src_rdy, eth.out_sof); else pass_cnt++;
        total_cnt++; if (eth.out_data !== 8'h11) $display("FAIL out_beat1_data got %h want 11", eth.out_data); else pass_cnt++;
        total_cnt++; if (ch_in_dst_rdy !== 3'b001) $display("FAIL out_beat1_dst_rdy got %b want 001", ch_in_dst_rdy); else pass_cnt++;
        @(negedge clk);
        eth.outport_addr = 4'd2; eth.out_dst_rdy = 1'b0;
        ch_in_sof = 3'b000; ch_in_eof = 3'b001; ch_in_data = 24'hA5_5A_22;
        #1;
        total_cnt++; if (eth.out_data !== 8'h22 || eth.out_eof !== 1'b1) $display("FAIL out_stall_data got %h eof%b want 22 1", eth.out_data, eth.out_eof); else pass_cnt++;
        total_cnt++; if (ch_in_dst_rdy !== 3'b000) $display("FAIL out_stall_dst_rdy got %b want 000", ch_in_dst_rdy); else pass_cnt++;
        total_cnt++; if (renables !== 16'h0002) $display("FAIL out_lock_renables got %h want 0002", renables); else pass_cnt++;
        @(negedge clk);
        eth.out_dst_rdy = 1'b1;
        #1;
        total_cnt++; if (ch_in_dst_rdy !== 3'b001) $display("FAIL out_beat2_dst_rdy got %b want 001", ch_in_dst_rdy); else pass_cnt++;
        total_cnt++; if (eth.out_data !== 8'h22) $display("FAIL out_beat2_data got %h want 22", eth.out_data); else pass_cnt++;
        @(negedge clk);
        ch_in_src_rdy = 3'b000; ch_in_eof = 3'b000;
        #1;
        total_cnt++; if (renables !== 16'h0004) $display("FAIL out_idle_renables got %h want 0004", renables); else pass_cnt++;
        total_cnt++; if (eth.out_src_rdy !== 1'b0) $display("FAIL out_idle_src_rdy got %b want 0", eth.out_src_rdy); else pass_cnt++;
        @(negedge clk);
        eth.outport_addr = 4'd0; ch_in_src_rdy = 3'b001;
        #1;
        total_cnt++; if (eth.out_src_rdy !== 1'b0 || eth.out_data !== 8'h00) $display("FAIL out_unmapped got src%b data%h want 0 00", eth.out_src_rdy, eth.out_data); else pass_cnt++;
        total_cnt++; if (ch_in_dst_rdy !== 3'b000) $display("FAIL out_unmapped_dst_rdy got %b want 000", ch_in_dst_rdy); else pass_cnt++;
        ch_in_src_rdy = 3'b000; eth.out_dst_rdy = 1'b0;
    endtask

    task automatic test_reset_midframe();
        in_beat(1'b1, 1'b0, 4'd1, 8'h31);
        in_beat(1'b0, 1'b0, 4'd1, 8'h32);
        @(negedge clk);
        rst = 1'b1; eth.in_data = 8'h33;
        #1;
        total_cnt++; if (eth.in_dst_rdy !== 1'b0) $display("FAIL midrst_in_dst_rdy got %b want 0", eth.in_dst_rdy); else pass_cnt++;
        total_cnt++; if (ch_out_src_rdy !== 3'b000) $display("FAIL midrst_src_rdy got %b want 000", ch_out_src_rdy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        eth.in_sof = 1'b0; eth.in_eof = 1'b0; eth.inport_addr = 4'd2; eth.in_data = 8'h34;
        #1;
        total_cnt++; if (ch_out_src_rdy !== 3'b000) $display("FAIL stray_src_rdy got %b want 000", ch_out_src_rdy); else pass_cnt++;
        total_cnt++; if (eth.in_dst_rdy !== 1'b1) $display("FAIL stray_in_dst_rdy got %b want 1", eth.in_dst_rdy); else pass_cnt++;
        total_cnt++; if (wenables !== 16'h0004) $display("FAIL stray_wenables got %h want 0004", wenables); else pass_cnt++;
        in_idle();
        total_cnt++; if (drop_cnt !== 8'd1) $display("FAIL stray_drop_cnt got %0d want 1", drop_cnt); else pass_cnt++;
        total_cnt++; if (in_frames !== 16'd0) $display("FAIL stray_in_frames got %0d want 0", in_frames); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            in_beat(1'b1, 1'b1, (i == 3) ? 4'd3 : 4'd1, 8'h40 + 8'(i));
            total_cnt++; if (in_frames !== 16'(i)) $display("FAIL b2b_in_frames beat%0d got %0d want %0d", i, in_frames, i); else pass_cnt++;
            total_cnt++; if (ch_out_src_rdy !== ((i == 3) ? 3'b100 : 3'b001)) $display("FAIL b2b_src_rdy beat%0d got %b", i, ch_out_src_rdy); else pass_cnt++;
        end
        ch_out_dst_rdy = 3'b110;
        in_beat(1'b1, 1'b1, 4'd1, 8'h50);
        total_cnt++; if (eth.in_dst_rdy !== 1'b0) $display("FAIL b2b_backpressure got %b want 0", eth.in_dst_rdy); else pass_cnt++;
        in_idle();
        total_cnt++; if (in_frames !== 16'd4) $display("FAIL b2b_final_in_frames got %0d want 4", in_frames); else pass_cnt++;
        ch_out_dst_rdy = 3'b111;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_change();
        test_drop();
        test_outbound();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
